// File: rtl/reg_bus_master_if.sv
// Command, register-bus and response signal bundle for reg_bus_master.
// The master modport is the view of reg_bus_master. The slave modport is the
// opposite side: the command issuer, the register slave and the response consumer.
interface reg_bus_master_if #(
  parameter int DW = 16,
  parameter int AW = 2
);
  // command channel
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_wr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_chk;
  logic [DW-1:0] cmd_exp;
  // register bus
  logic          sel;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  // response channel
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_mismatch;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_chk, cmd_exp,
    input  rdata, rsp_ready,
    output cmd_ready, sel, wr, addr, wdata,
    output rsp_valid, rsp_rdata, rsp_mismatch
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, cmd_chk, cmd_exp,
    output rdata, rsp_ready,
    input  cmd_ready, sel, wr, addr, wdata,
    input  rsp_valid, rsp_rdata, rsp_mismatch
  );
endinterface

// File: rtl/reg_bus_master.sv
// Register-bus master. It takes one command at a time. It runs a single-cycle
// write or read on the register bus. For a read, it waits RD_LAT cycles and then
// captures rdata, optionally comparing it with an expected value. It holds the
// response until the consumer takes it. It also counts completed transactions
// and read mismatches.
module reg_bus_master #(
  parameter int DW     = 16,
  parameter int AW     = 2,
  parameter int RD_LAT = 1   // legal range 1..4
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_bus_master_if.master     bus,
  output logic                 o_busy,
  output logic [15:0]          o_txn_cnt,
  output logic [7:0]           o_err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD      = 3'd2,
    S_RD_WAIT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_exp;
  logic          r_chk;
  logic [2:0]    r_wait;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_mismatch;
  logic [15:0]   r_txn_cnt;
  logic [7:0]    r_err_cnt;

  logic          w_accept;
  logic          w_capture;
  logic          w_resp_done;

  // Decode the event strobes from the registered state and the handshake inputs.
  assign w_accept    = (r_state == S_IDLE) && bus.cmd_valid;
  assign w_capture   = (r_state == S_RD_WAIT) && (r_wait == 3'd1);
  assign w_resp_done = (r_state == S_RESP) && bus.rsp_ready;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Compute the next state. Drive the bus, response and status outputs from the registered state only.
  always_comb begin
    w_state_next     = r_state;
    bus.sel          = 1'b0;
    bus.wr           = 1'b0;
    bus.addr         = '0;
    bus.wdata        = '0;
    bus.rsp_valid    = 1'b0;
    bus.rsp_rdata    = r_rsp_rdata;
    bus.rsp_mismatch = r_rsp_mismatch;
    // While reset is held, refuse commands even though the state reads IDLE.
    bus.cmd_ready    = (r_state == S_IDLE) && !reset;
    o_busy           = (r_state != S_IDLE);
    o_txn_cnt        = r_txn_cnt;
    o_err_cnt        = r_err_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) w_state_next = bus.cmd_wr ? S_WR : S_RD;
      end
      S_WR: begin
        bus.sel      = 1'b1;
        bus.wr       = 1'b1;
        bus.addr     = r_addr;
        bus.wdata    = r_wdata;
        w_state_next = S_RESP;
      end
      S_RD: begin
        bus.sel      = 1'b1;
        bus.addr     = r_addr;
        w_state_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (w_capture) w_state_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch the command, run the read-wait counter, capture the response and update the counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr         <= '0;
      r_wdata        <= '0;
      r_exp          <= '0;
      r_chk          <= 1'b0;
      r_wait         <= 3'd0;
      r_rsp_rdata    <= '0;
      r_rsp_mismatch <= 1'b0;
      r_txn_cnt      <= 16'd0;
      r_err_cnt      <= 8'd0;
    end else begin
      if (w_accept) begin
        r_addr         <= bus.cmd_addr;
        r_wdata        <= bus.cmd_wdata;
        r_exp          <= bus.cmd_exp;
        r_chk          <= bus.cmd_chk;
        // Clear the response up front so that a write always answers with 0 and no mismatch.
        r_rsp_rdata    <= '0;
        r_rsp_mismatch <= 1'b0;
      end
      if (r_state == S_RD) r_wait <= 3'(RD_LAT);
      if (r_state == S_RD_WAIT) r_wait <= r_wait - 3'd1;
      if (w_capture) begin
        r_rsp_rdata    <= bus.rdata;
        r_rsp_mismatch <= r_chk && (bus.rdata != r_exp);
      end
      if (w_resp_done) begin
        r_txn_cnt <= r_txn_cnt + 16'd1;
        if (r_rsp_mismatch && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Self-checking bench for reg_bus_master (RD_LAT = 2) with a simple register-file slave.
module tb_reg_bus_master;
  localparam int DW     = 16;
  localparam int AW     = 2;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        busy;
  logic [15:0] txn_cnt;
  logic [7:0]  err_cnt;

  reg_bus_master_if #(.DW(DW), .AW(AW)) bus_if ();

  reg_bus_master #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.master),
    .o_busy    (busy),
    .o_txn_cnt (txn_cnt),
    .o_err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  // register-file slave: writes on a write strobe, registered read data held until the next read
  logic [15:0] slv_regs [0:3] = '{16'h0, 16'h0, 16'h0, 16'h0};
  always @(posedge clk) begin
    if (bus_if.sel) begin
      if (bus_if.wr) slv_regs[bus_if.addr] <= bus_if.wdata;
      else           bus_if.rdata <= slv_regs[bus_if.addr];
    end
  end

  // reference model
  logic [15:0] m_regs [0:3];
  int          exp_txn;
  int          exp_err;
  int          checks;
  int          fails;

  // observations from run_txn
  int          obs_lat, obs_sel_cyc, obs_wr_cyc;
  logic [15:0] obs_wdata, obs_rdata;
  logic [1:0]  obs_addr;
  logic        obs_mism, obs_stable, obs_dirty, obs_to;

  task automatic run_txn(input logic w, input logic [1:0] a, input logic [15:0] d,
                         input logic chk, input logic [15:0] e, input int hold);
    int k;
    obs_sel_cyc = 0; obs_wr_cyc = 0; obs_wdata = '0; obs_addr = '0;
    obs_dirty = 1'b0; obs_to = 1'b0; obs_stable = 1'b1; obs_lat = -1;
    @(negedge clk);
    bus_if.cmd_wr = w; bus_if.cmd_addr = a; bus_if.cmd_wdata = d;
    bus_if.cmd_chk = chk; bus_if.cmd_exp = e; bus_if.cmd_valid = 1'b1;
    k = 0;
    while (!bus_if.cmd_ready && k < 50) begin @(negedge clk); k++; end
    if (!bus_if.cmd_ready) obs_to = 1'b1;
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    k = 0;
    while (1) begin
      if (bus_if.sel) begin
        obs_sel_cyc++;
        obs_addr = bus_if.addr;
        if (bus_if.wr) begin obs_wr_cyc++; obs_wdata = bus_if.wdata; end
      end else if (bus_if.wr !== 1'b0 || bus_if.addr !== '0 || bus_if.wdata !== '0) begin
        obs_dirty = 1'b1;
      end
      if (bus_if.rsp_valid === 1'b1) break;
      if (k >= 50) begin obs_to = 1'b1; break; end
      @(negedge clk); k++;
    end
    obs_lat   = k;
    obs_rdata = bus_if.rsp_rdata;
    obs_mism  = bus_if.rsp_mismatch;
    repeat (hold) begin
      @(negedge clk);
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== obs_rdata ||
          bus_if.rsp_mismatch !== obs_mism || bus_if.cmd_ready !== 1'b0 || bus_if.sel !== 1'b0)
        obs_stable = 1'b0;
    end
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    if (bus_if.rsp_valid !== 1'b0) obs_stable = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus_if.cmd_valid = 1'b0; bus_if.rsp_ready = 1'b0;
    bus_if.cmd_wr = 1'b0; bus_if.cmd_addr = '0; bus_if.cmd_wdata = '0;
    bus_if.cmd_chk = 1'b0; bus_if.cmd_exp = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_if.cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready got=%b want=0", bus_if.cmd_ready); end
    checks++;
    if ({bus_if.sel, bus_if.wr, bus_if.addr, bus_if.wdata} !== '0) begin
      fails++; $display("FAIL reset_bus got sel=%b wr=%b addr=%h wdata=%h want all 0", bus_if.sel, bus_if.wr, bus_if.addr, bus_if.wdata);
    end
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_mismatch, bus_if.rsp_rdata, busy, txn_cnt, err_cnt} !== '0) begin
      fails++; $display("FAIL reset_rsp got valid=%b mism=%b rdata=%h busy=%b txn=%0d err=%0d want all 0",
                        bus_if.rsp_valid, bus_if.rsp_mismatch, bus_if.rsp_rdata, busy, txn_cnt, err_cnt);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (bus_if.cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b want=1", bus_if.cmd_ready); end
    $display("txn reset: released, cmd_ready=%b", bus_if.cmd_ready);
  endtask

  // issues one command and checks every observable against the model
  task automatic test_txn(input string name, input logic w, input logic [1:0] a, input logic [15:0] d,
                          input logic chk, input logic [15:0] e, input int hold);
    logic [15:0] x_rdata;
    logic        x_mism;
    int          x_lat;
    x_rdata = w ? 16'h0 : m_regs[a];
    x_mism  = !w && chk && (m_regs[a] != e);
    x_lat   = w ? 1 : 1 + RD_LAT;
    run_txn(w, a, d, chk, e, hold);
    if (w) m_regs[a] = d;
    exp_txn = (exp_txn + 1) % 65536;
    if (x_mism && exp_err < 255) exp_err++;
    checks++;
    if (obs_to !== 1'b0) begin fails++; $display("FAIL %s_timeout got=%b want=0", name, obs_to); end
    checks++;
    if (obs_lat != x_lat) begin fails++; $display("FAIL %s_latency got=%0d want=%0d", name, obs_lat, x_lat); end
    checks++;
    if (obs_sel_cyc != 1 || obs_wr_cyc != (w ? 1 : 0) || obs_addr !== a || obs_dirty !== 1'b0) begin
      fails++; $display("FAIL %s_bus got sel_cyc=%0d wr_cyc=%0d addr=%0d dirty=%b want 1/%0d/%0d/0",
                        name, obs_sel_cyc, obs_wr_cyc, obs_addr, obs_dirty, w ? 1 : 0, a);
    end
    if (w) begin
      checks++;
      if (obs_wdata !== d) begin fails++; $display("FAIL %s_wdata got=%h want=%h", name, obs_wdata, d); end
    end
    checks++;
    if (obs_rdata !== x_rdata || obs_mism !== x_mism) begin
      fails++; $display("FAIL %s_rsp got rdata=%h mism=%b want rdata=%h mism=%b", name, obs_rdata, obs_mism, x_rdata, x_mism);
    end
    checks++;
    if (obs_stable !== 1'b1) begin fails++; $display("FAIL %s_resp_hold got stable=%b want=1", name, obs_stable); end
    checks++;
    if (txn_cnt !== 16'(exp_txn) || err_cnt !== 8'(exp_err)) begin
      fails++; $display("FAIL %s_counters got txn=%0d err=%0d want txn=%0d err=%0d", name, txn_cnt, err_cnt, exp_txn, exp_err);
    end
    $display("txn %s: wr=%b addr=%0d wdata=%h chk=%b exp=%h -> rdata=%h mism=%b lat=%0d txn=%0d err=%0d",
             name, w, a, d, chk, e, obs_rdata, obs_mism, obs_lat, txn_cnt, err_cnt);
  endtask

  task automatic test_directed;
    test_txn("rd0_zero",    1'b0, 2'd0, 16'h0000, 1'b1, 16'h0000, 0);
    test_txn("wr0_1234",    1'b1, 2'd0, 16'h1234, 1'b0, 16'h0000, 0);
    test_txn("rd0_1234",    1'b0, 2'd0, 16'h0000, 1'b1, 16'h1234, 0);
    test_txn("wr1_5678",    1'b1, 2'd1, 16'h5678, 1'b1, 16'hFFFF, 0);
    test_txn("rd1_mism",    1'b0, 2'd1, 16'h0000, 1'b1, 16'hABCD, 0);
    test_txn("rd1_hold5",   1'b0, 2'd1, 16'h0000, 1'b0, 16'h0000, 5);
  endtask

  task automatic test_random;
    logic        w, chk;
    logic [1:0]  a;
    logic [15:0] d, e;
    for (int i = 0; i < 40; i++) begin
      w   = 1'($urandom_range(0, 1));
      a   = 2'($urandom_range(0, 3));
      d   = 16'($urandom);
      chk = 1'($urandom_range(0, 1));
      e   = ($urandom_range(0, 1) == 1) ? m_regs[a] : 16'($urandom);
      test_txn($sformatf("rand%0d", i), w, a, d, chk, e, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 6;
    logic        bw   [N];
    logic [1:0]  ba   [N];
    logic [15:0] bd   [N];
    logic [15:0] xr   [N];
    logic [15:0] gr   [N];
    int          acc_t[N];
    int          rsp_t[N];
    int          issued, done, t, x_lat;
    for (int i = 0; i < N; i++) begin
      bw[i] = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      ba[i] = 2'($urandom_range(0, 3));
      bd[i] = 16'($urandom);
      acc_t[i] = -100; rsp_t[i] = -100; gr[i] = '0; xr[i] = '0;
    end
    issued = 0; done = 0; t = 0;
    bus_if.rsp_ready = 1'b1;
    bus_if.cmd_chk = 1'b0;
    @(negedge clk);
    while (done < N && t < 400) begin
      if (bus_if.rsp_valid === 1'b1) begin rsp_t[done] = t; gr[done] = bus_if.rsp_rdata; done++; end
      if (bus_if.cmd_ready === 1'b1) begin
        if (issued < N) begin
          bus_if.cmd_wr = bw[issued]; bus_if.cmd_addr = ba[issued]; bus_if.cmd_wdata = bd[issued];
          bus_if.cmd_valid = 1'b1;
          acc_t[issued] = t;
          xr[issued] = bw[issued] ? 16'h0 : m_regs[ba[issued]];
          if (bw[issued]) m_regs[ba[issued]] = bd[issued];
          issued++;
        end else begin
          bus_if.cmd_valid = 1'b0;
        end
      end
      @(negedge clk); t++;
    end
    bus_if.cmd_valid = 1'b0;
    bus_if.rsp_ready = 1'b0;
    exp_txn = (exp_txn + N) % 65536;
    checks++;
    if (done != N) begin fails++; $display("FAIL b2b_timeout got=%0d responses want=%0d", done, N); end
    for (int i = 0; i < N; i++) begin
      x_lat = bw[i] ? 1 : 1 + RD_LAT;
      checks++;
      if (rsp_t[i] - acc_t[i] - 1 != x_lat) begin
        fails++; $display("FAIL b2b%0d_latency got=%0d want=%0d", i, rsp_t[i] - acc_t[i] - 1, x_lat);
      end
      if (i > 0) begin
        checks++;
        if (acc_t[i] - rsp_t[i-1] != 1) begin
          fails++; $display("FAIL b2b%0d_accept_gap got=%0d want=1", i, acc_t[i] - rsp_t[i-1]);
        end
      end
      checks++;
      if (gr[i] !== xr[i]) begin fails++; $display("FAIL b2b%0d_rdata got=%h want=%h", i, gr[i], xr[i]); end
      $display("txn b2b%0d: wr=%b addr=%0d wdata=%h accept@%0d rsp@%0d rdata=%h",
               i, bw[i], ba[i], bd[i], acc_t[i], rsp_t[i], gr[i]);
    end
    checks++;
    if (txn_cnt !== 16'(exp_txn)) begin fails++; $display("FAIL b2b_txn_cnt got=%0d want=%0d", txn_cnt, exp_txn); end
  endtask

  task automatic test_reset_mid;
    logic saw_valid;
    @(negedge clk);
    bus_if.cmd_wr = 1'b0; bus_if.cmd_addr = 2'd3; bus_if.cmd_chk = 1'b1; bus_if.cmd_exp = 16'h0;
    bus_if.cmd_valid = 1'b1;
    @(negedge clk);                 // RD
    bus_if.cmd_valid = 1'b0;
    @(negedge clk);                 // RD_WAIT
    checks++;
    if (busy !== 1'b1 || bus_if.sel !== 1'b0) begin
      fails++; $display("FAIL rstmid_pre got busy=%b sel=%b want busy=1 sel=0", busy, bus_if.sel);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus_if.sel, bus_if.wr, bus_if.addr, bus_if.wdata, bus_if.rsp_valid, bus_if.rsp_rdata,
         bus_if.rsp_mismatch, busy, txn_cnt, err_cnt, bus_if.cmd_ready} !== '0) begin
      fails++; $display("FAIL rstmid_outputs got sel=%b valid=%b rdata=%h busy=%b txn=%0d err=%0d ready=%b want all 0",
                        bus_if.sel, bus_if.rsp_valid, bus_if.rsp_rdata, busy, txn_cnt, err_cnt, bus_if.cmd_ready);
    end
    saw_valid = 1'b0;
    repeat (3) begin @(negedge clk); if (bus_if.rsp_valid !== 1'b0) saw_valid = 1'b1; end
    bus_if.cmd_wr = 1'b1; bus_if.cmd_addr = 2'd2; bus_if.cmd_wdata = 16'h00FF; bus_if.cmd_chk = 1'b1;
    bus_if.cmd_valid = 1'b1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus_if.cmd_ready !== 1'b1 || saw_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_release got ready=%b saw_valid=%b want ready=1 saw_valid=0", bus_if.cmd_ready, saw_valid);
    end
    @(negedge clk);
    bus_if.cmd_valid = 1'b0;
    checks++;
    if (bus_if.wr !== 1'b1 || bus_if.addr !== 2'd2 || bus_if.wdata !== 16'h00FF) begin
      fails++; $display("FAIL rstmid_first_accept got wr=%b addr=%0d wdata=%h want 1/2/00ff", bus_if.wr, bus_if.addr, bus_if.wdata);
    end
    @(negedge clk);
    checks++;
    if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_rdata !== 16'h0 || bus_if.rsp_mismatch !== 1'b0) begin
      fails++; $display("FAIL rstmid_wr_rsp got valid=%b rdata=%h mism=%b want 1/0000/0",
                        bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_mismatch);
    end
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    bus_if.rsp_ready = 1'b0;
    m_regs[2] = 16'h00FF;
    exp_txn = 1; exp_err = 0;
    checks++;
    if (txn_cnt !== 16'd1 || err_cnt !== 8'd0) begin
      fails++; $display("FAIL rstmid_counters got txn=%0d err=%0d want 1/0", txn_cnt, err_cnt);
    end
    $display("txn rstmid: aborted read, then write addr=2 wdata=00ff txn=%0d", txn_cnt);
  endtask

  task automatic test_err_saturate;
    for (int i = 0; i < 258; i++) begin
      run_txn(1'b0, 2'd0, 16'h0, 1'b1, ~m_regs[0], 0);
      exp_txn++;
      if (exp_err < 255) exp_err++;
    end
    checks++;
    if (err_cnt !== 8'(exp_err) || txn_cnt !== 16'(exp_txn)) begin
      fails++; $display("FAIL err_saturate got err=%0d txn=%0d want err=%0d txn=%0d", err_cnt, txn_cnt, exp_err, exp_txn);
    end
    $display("txn err_saturate: 258 mismatching reads -> err=%0d txn=%0d", err_cnt, txn_cnt);
  endtask

  initial begin
    checks = 0; fails = 0; exp_txn = 0; exp_err = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 16'h0;
    bus_if.rsp_ready = 1'b0;
    bus_if.cmd_valid = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_err_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
